calc_cmd_sequencer: RTL and testbench

- Sits between the keypad/command source and the calculator core.
- Buffers command codes in a small FIFO and issues them one at a time on the core's cmd input, using the core's 2-bit status handshake.
- Detects core errors and stalls (timeouts), and sequences an error-recovery reset of the core.
- Optionally shadows the core's multiplexed display scan (data/pos) into a parallel 8-digit register.

---
 rtl/calc_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: buffers keypad command codes in a small FIFO and issues
// them one at a time to the calculator core over its 2-bit status handshake.
// Core errors and stalls (timeouts) park the sequencer in ERROR until
// err_clear, after which the core is held in reset for RST_CYCLES cycles.
// Optional display shadow capture is enabled by defining CALC_SEQ_DISP_CAPTURE_EN.
module calc_cmd_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [3:0]  IDLE_CMD   = 4'hD,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic                     key_ready,
  output logic [3:0]               cmd_out,
  output logic                     calc_reset,
  input  logic [1:0]               calc_status,
  input  logic [3:0]               calc_data,
  input  logic [3:0]               calc_pos,
  input  logic                     err_clear,
  output logic                     busy,
  output logic                     error,
  output logic                     err_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              disp_digits,
  output logic                     disp_valid
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned TMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_READY,
    S_ERROR,
    S_RECOVER
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            key_ready_q;
  logic [3:0]      issued_q, issued_d;
  logic            error_q, error_d;
  logic            etmo_q, etmo_d;
  logic            push, pop, flush;
  logic [3:0]      head;

  assign head = mem_q[rptr_q];
  assign push = key_valid && key_ready_q;

  // Next-state decode; status 00 is checked before the timeout so a core
  // error is never reported as a timeout.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    flush    = 1'b0;
    error_d  = error_q;
    etmo_d   = etmo_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (calc_status == ST_ERR) begin
          state_d = S_ERROR;
          flush   = 1'b1;
          error_d = 1'b1;
          etmo_d  = 1'b0;
        end else if (cnt_q != '0 && calc_status == ST_READY) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issued_d = head;
        pop      = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (calc_status == ST_ERR) begin
          state_d = S_ERROR;
          flush   = 1'b1;
          error_d = 1'b1;
          etmo_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
          flush   = 1'b1;
          error_d = 1'b1;
          etmo_d  = 1'b1;
        end else if (calc_status == ST_BUSY) begin
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (calc_status == ST_ERR) begin
          state_d = S_ERROR;
          flush   = 1'b1;
          error_d = 1'b1;
          etmo_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
          flush   = 1'b1;
          error_d = 1'b1;
          etmo_d  = 1'b1;
        end else if (calc_status == ST_READY) begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (err_clear) state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (tmo_q == RST_LAST) begin
          state_d = S_IDLE;
          flush   = 1'b1;
          error_d = 1'b0;
          etmo_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating per-state cycle counter, cleared on every state change; it
  // times both the wait-state timeouts and the recovery reset pulse.
  always_comb begin
    if (state_d != state_q)  tmo_d = '0;
    else if (tmo_q == '1)    tmo_d = tmo_q;
    else                     tmo_d = tmo_q + TW'(1);
  end

  // FIFO pointer/count update; a flush overrides any push in the same cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      key_ready_q <= 1'b1;
      issued_q    <= IDLE_CMD;
      error_q     <= 1'b0;
      etmo_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      key_ready_q <= (cnt_d != FULL);
      issued_q    <= issued_d;
      error_q     <= error_d;
      etmo_q      <= etmo_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wptr_q] <= key_code;
  end

  // Command output: FIFO head for the single ISSUE cycle, then the latched
  // code until the core reports busy.
  always_comb begin
    cmd_out = IDLE_CMD;
    case (state_q)
      S_ISSUE:     cmd_out = head;
      S_WAIT_BUSY: cmd_out = issued_q;
      default:     cmd_out = IDLE_CMD;
    endcase
  end

  assign key_ready   = key_ready_q;
  assign fifo_count  = cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign error       = error_q;
  assign err_timeout = etmo_q;
  assign calc_reset  = (state_q == S_RECOVER);

`ifdef CALC_SEQ_DISP_CAPTURE_EN
  logic [31:0] disp_q, disp_d;
  logic [2:0]  seq_q, seq_d;
  logic        dvalid_q, dvalid_d;
  logic        cap;

  assign cap = (calc_status != ST_READY) && (calc_pos < 4'd8);

  // Shadow the scanned digit and track an in-order 0..7 scan; any
  // out-of-order position restarts tracking (at 1 if it was position 0).
  always_comb begin
    disp_d   = disp_q;
    seq_d    = seq_q;
    dvalid_d = 1'b0;
    if (cap) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (calc_pos[2:0] == 3'(i)) disp_d[4*i +: 4] = calc_data;
      end
      if (calc_pos[2:0] == seq_q) begin
        if (seq_q == 3'd7) begin
          dvalid_d = 1'b1;
          seq_d    = 3'd0;
        end else begin
          seq_d = seq_q + 3'd1;
        end
      end else begin
        seq_d = (calc_pos[2:0] == 3'd0) ? 3'd1 : 3'd0;
      end
    end
  end

  // Display shadow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_q   <= '0;
      seq_q    <= '0;
      dvalid_q <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      seq_q    <= seq_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign disp_digits = disp_q;
  assign disp_valid  = dvalid_q;
`else
  logic [7:0] unused_disp;
  assign unused_disp = {calc_data, calc_pos};
  assign disp_digits = '0;
  assign disp_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Testbench for calc_cmd_sequencer: randomized key pushes against a
// queue-based reference of the command stream, plus directed fill, error,
// timeout, recovery and async-reset scenarios.
module tb_calc_cmd_sequencer;
  localparam int          DEPTH      = 8;
  localparam int          TIMEOUT    = 1024;
  localparam int          RST_CYCLES = 4;
  localparam logic [3:0]  IDLE_CMD   = 4'hD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_ready;
  logic [3:0]  cmd_out;
  logic        calc_reset;
  logic [1:0]  calc_status = 2'b10;
  logic [3:0]  calc_data = 4'h0;
  logic [3:0]  calc_pos = 4'h8;
  logic        err_clear = 1'b0;
  logic        busy, error, err_timeout;
  logic [3:0]  fifo_count;
  logic [31:0] disp_digits;
  logic        disp_valid;

  calc_cmd_sequencer #(
    .DEPTH(DEPTH), .IDLE_CMD(IDLE_CMD), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .cmd_out(cmd_out), .calc_reset(calc_reset),
    .calc_status(calc_status), .calc_data(calc_data), .calc_pos(calc_pos),
    .err_clear(err_clear), .busy(busy), .error(error), .err_timeout(err_timeout),
    .fifo_count(fifo_count), .disp_digits(disp_digits), .disp_valid(disp_valid)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  int         m_cnt = 0;
  bit         acc_pend = 0, pop_pend = 0, flush_pend = 0, mon_en = 0;
  logic [3:0] prev_cmd = 4'hD;
  bit         core_auto = 0;
  int         cph = 0, cdly = 0, cbsy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] rnd_code();
    logic [3:0] c;
    c = 4'($urandom_range(0, 14));
    if (c >= 4'hD) c = c + 4'd1;
    return c;
  endfunction

  // Simple core: goes busy a few cycles after seeing a command, then ready.
  task automatic core_step();
    if (cph == 0) begin
      calc_status = 2'b10;
      if (cmd_out != IDLE_CMD) begin cdly = $urandom_range(0, 2); cph = 1; end
    end
    if (cph == 1) begin
      if (cdly == 0) begin calc_status = 2'b01; cbsy = $urandom_range(1, 4); cph = 2; end
      else cdly--;
    end else if (cph == 2) begin
      if (cbsy == 0) begin calc_status = 2'b10; cph = 0; end
      else cbsy--;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
    key_valid = 1'b0;
    acc_pend  = 1'b0;
    if (core_auto) core_step();
  endtask

  task automatic drive_key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    if (m_cnt < DEPTH) begin
      exp_q.push_back(c);
      acc_pend = 1'b1;
    end
  endtask

  task automatic wait_issue();
    int n = 0;
    while (cmd_out == IDLE_CMD && n < 20) begin tick(); n++; end
    check("issue_seen", 32'(cmd_out != IDLE_CMD), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_cnt != 0 || exp_q.size() != 0 || cmd_out != IDLE_CMD || busy) && n < 2000) begin
      tick(); n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic recover();
    calc_status = 2'b10;
    err_clear   = 1'b1;
    tick();
    err_clear = 1'b0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      check("rec_calc_reset", 32'(calc_reset), 32'd1);
      check("rec_error_held", 32'(error), 32'd1);
      if (i == RST_CYCLES - 1) flush_pend = 1'b1;
      tick();
    end
    check("rec_calc_reset_end", 32'(calc_reset), 32'd0);
    check("rec_error_clr", 32'(error), 32'd0);
    check("rec_tmo_clr", 32'(err_timeout), 32'd0);
    check("rec_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: maintains the expected FIFO occupancy and compares every issued
  // command against the scoreboard queue.
  always @(negedge clock) begin
    if (mon_en) begin
      if (flush_pend) begin
        m_cnt = 0;
        exp_q.delete();
        flush_pend = 1'b0;
      end else begin
        m_cnt = m_cnt + int'(acc_pend) - int'(pop_pend);
      end
      pop_pend = 1'b0;
      check("fifo_count", 32'(fifo_count), 32'(m_cnt));
      check("key_ready", 32'(key_ready), 32'(m_cnt < DEPTH));
      if (cmd_out != IDLE_CMD && prev_cmd == IDLE_CMD) begin
        if (exp_q.size() == 0) check("issue_unexpected", 32'(cmd_out), 32'(IDLE_CMD));
        else check("issue_code", 32'(cmd_out), 32'(exp_q.pop_front()));
        pop_pend = 1'b1;
      end else if (cmd_out != IDLE_CMD) begin
        check("cmd_hold", 32'(cmd_out), 32'(prev_cmd));
      end
      if (cmd_out != IDLE_CMD) check("busy_on_issue", 32'(busy), 32'd1);
`ifndef CALC_SEQ_DISP_CAPTURE_EN
      check("disp_digits_off", disp_digits, 32'd0);
      check("disp_valid_off", 32'(disp_valid), 32'd0);
`endif
      prev_cmd = cmd_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    // Reset with a push request pending.
    reset = 1'b0; key_valid = 1'b1; key_code = 4'h3;
    repeat (2) @(negedge clock);
    check("rst_cmd_out", 32'(cmd_out), 32'(IDLE_CMD));
    check("rst_calc_reset", 32'(calc_reset), 32'd0);
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_disp_digits", disp_digits, 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    key_valid = 1'b0;
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();
    check("post_rst_cmd", 32'(cmd_out), 32'(IDLE_CMD));
    check("post_rst_ready", 32'(key_ready), 32'd1);

    // Randomized traffic with a responsive core.
    core_auto = 1'b1;
    repeat (300) begin
      tick();
      if ($urandom_range(0, 1) == 1) drive_key(rnd_code());
    end
    drain();
    core_auto = 1'b0; cph = 0; calc_status = 2'b10;

    // Fill with the core busy: ninth push dropped.
    calc_status = 2'b01;
    repeat (DEPTH + 1) begin tick(); drive_key(rnd_code()); end
    tick();
    check("fill_count", 32'(fifo_count), 32'(DEPTH));
    check("fill_ready", 32'(key_ready), 32'd0);

    // Asynchronous reset mid-operation.
    reset = 1'b0;
    #1;
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_ready", 32'(key_ready), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    flush_pend = 1'b1;
    tick();
    reset = 1'b1;
    calc_status = 2'b10;
    tick();

    // Core error while waiting for busy.
    tick(); drive_key(rnd_code());
    tick(); drive_key(rnd_code());
    tick();
    wait_issue();
    tick();
    check("wb_cmd_held", 32'(cmd_out != IDLE_CMD), 32'd1);
    calc_status = 2'b00;
    flush_pend  = 1'b1;
    tick();
    check("err_set", 32'(error), 32'd1);
    check("err_not_tmo", 32'(err_timeout), 32'd0);
    check("err_cmd_idle", 32'(cmd_out), 32'(IDLE_CMD));
    check("err_busy", 32'(busy), 32'd1);
    drive_key(rnd_code());
    tick();
    check("err_push_count", 32'(fifo_count), 32'd1);
    recover();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clear_ignored_rst", 32'(calc_reset), 32'd0);
    check("clear_ignored_busy", 32'(busy), 32'd0);

    // Timeout in WAIT_READY with status held busy.
    tick(); drive_key(rnd_code());
    tick();
    wait_issue();
    calc_status = 2'b01;
    tick();
    tick();
    check("wr_cmd_idle", 32'(cmd_out), 32'(IDLE_CMD));
    check("wr_busy", 32'(busy), 32'd1);
    n = 0;
    while (!error && n < TIMEOUT + 100) begin tick(); n++; end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_flag", 32'(err_timeout), 32'd1);
    recover();

`ifdef CALC_SEQ_DISP_CAPTURE_EN
    // Display scan 0..7 with data 5,2,0,... while the core is busy.
    calc_status = 2'b01;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (disp_valid) pulses++;
      calc_pos  = 4'(i);
      calc_data = (i == 0) ? 4'h5 : (i == 1) ? 4'h2 : 4'h0;
    end
    repeat (4) begin
      tick();
      if (disp_valid) pulses++;
      calc_pos = 4'h8;
    end
    check("disp_digits", disp_digits, 32'h0000_0025);
    check("disp_pulses", 32'(pulses), 32'd1);
    calc_status = 2'b10;
`else
    pulses = 0;
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
